// File: rtl/del_gen_pkg.sv
// Shared constants and state type for the delayed pulse generator.
package del_gen_pkg;

  localparam int unsigned DW   = 16;
  localparam int unsigned N_CH = 4;
  localparam int unsigned CW   = DW + 1;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } state_e;

endpackage

// File: rtl/del_chan_pulse.sv
// One channel: output goes high when the run counter reaches di, low PW cycles later.
module del_chan_pulse #(
  parameter int unsigned DW = 16,
  parameter int unsigned PW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run,
  input  logic [DW:0]   counter,
  input  logic [DW-1:0] di,
  output logic          out
);

  localparam int unsigned CntW = DW + 1;

  logic [CntW-1:0] t_on;
  logic [CntW-1:0] t_off;
  logic            out_q;
  logic            out_d;

  assign t_on  = {1'b0, di};
  assign t_off = t_on + CntW'(PW);

  // PW >= 1 keeps the set and clear compares from matching on the same count.
  always_comb begin
    out_d = out_q;
    if (!run) begin
      out_d = 1'b0;
    end else if (counter == t_off) begin
      out_d = 1'b0;
    end else if (counter == t_on) begin
      out_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q <= 1'b0;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: rtl/del_pulse_gen.sv
// Four-channel delayed pulse generator; the run length is set by the channel at max_idx.
module del_pulse_gen #(
  parameter int unsigned DW = del_gen_pkg::DW,
  parameter int unsigned PW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          trig,
  input  logic [DW-1:0] DATA0,
  input  logic [DW-1:0] DATA1,
  input  logic [DW-1:0] DATA2,
  input  logic [DW-1:0] DATA3,
  input  logic [1:0]    max_idx,
  output logic [3:0]    out,
  output logic          busy,
  output logic          done,
  output logic          ovr,
  output logic          err
);

  import del_gen_pkg::*;

  localparam int unsigned CntW = DW + 1;

  state_e                   state_q, state_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic [N_CH-1:0][DW-1:0]  data_q, data_d;
  logic [N_CH-1:0][DW-1:0]  data_in;
  logic [1:0]               idx_q, idx_d;
  logic                     trig_q;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     ovr_q, ovr_d;
  logic                     err_q, err_d;

  logic                     trig_edge;
  logic [DW-1:0]            dmax;
  logic                     end_hit;
  logic                     over_max;
  logic                     chan_run;

  assign data_in   = {DATA3, DATA2, DATA1, DATA0};
  assign trig_edge = trig & ~trig_q;
  assign dmax      = data_q[idx_q];
  assign end_hit   = (state_q == StRun) && (cnt_q == ({1'b0, dmax} + CntW'(PW)));
  // Channels are forced low on the end edge, truncating any delay beyond dmax.
  assign chan_run  = (state_q == StRun) && !end_hit;

  always_comb begin
    over_max = 1'b0;
    for (int i = 0; i < int'(N_CH); i++) begin
      if (data_in[i] > data_in[max_idx]) begin
        over_max = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovr_d   = ovr_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (trig_edge) begin
          state_d = StRun;
          cnt_d   = '0;
          data_d  = data_in;
          idx_d   = max_idx;
          busy_d  = 1'b1;
          err_d   = over_max;
          ovr_d   = 1'b0;
        end
      end
      StRun: begin
        if (trig_edge) begin
          ovr_d = 1'b1;
        end
        if (end_hit) begin
          state_d = StIdle;
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      trig_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      trig_q  <= trig;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
      err_q   <= err_d;
    end
  end

  for (genvar i = 0; i < int'(N_CH); i++) begin : g_chan
    del_chan_pulse #(
      .DW(DW),
      .PW(PW)
    ) u_chan (
      .clk    (clk),
      .reset  (reset),
      .run    (chan_run),
      .counter(cnt_q),
      .di     (data_q[i]),
      .out    (out[i])
    );
  end

  assign busy = busy_q;
  assign done = done_q;
  assign ovr  = ovr_q;
  assign err  = err_q;

endmodule

// File: tb/tb_del_pulse_gen.sv
// Directed bench for del_pulse_gen: table of hand-computed runs plus reset corner cases.
module tb_del_pulse_gen;

  localparam int unsigned DW = 16;
  localparam int unsigned PW = 8;

  logic          clk;
  logic          reset;
  logic          trig;
  logic [DW-1:0] DATA0, DATA1, DATA2, DATA3;
  logic [1:0]    max_idx;
  logic [3:0]    out;
  logic          busy, done, ovr, err;

  // Rise edges are counted after the accept edge k; -1 means the channel never fires.
  typedef struct {
    logic [15:0] d0, d1, d2, d3;
    logic [1:0]  idx;
    int          r0, r1, r2, r3;
    int          done_at;
    logic        err;
    int          ovr_at;
  } vec_t;

  vec_t vecs [5];
  int   n_checks;
  int   n_fail;
  int   cur_sc;
  int   cur_j;

  del_pulse_gen #(
    .DW(DW),
    .PW(PW)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .trig   (trig),
    .DATA0  (DATA0),
    .DATA1  (DATA1),
    .DATA2  (DATA2),
    .DATA3  (DATA3),
    .max_idx(max_idx),
    .out    (out),
    .busy   (busy),
    .done   (done),
    .ovr    (ovr),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s (scenario %0d, edge k+%0d): got %0h, expected %0h",
               name, cur_sc, cur_j, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rise_of(input vec_t v, input int i);
    case (i)
      0:       return v.r0;
      1:       return v.r1;
      2:       return v.r2;
      default: return v.r3;
    endcase
  endfunction

  function automatic logic [3:0] exp_out(input vec_t v, input int j);
    logic [3:0] r;
    r = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      int rr;
      rr = rise_of(v, i);
      if (rr >= 0 && j >= rr && j < rr + int'(PW) && j < v.done_at) r[i] = 1'b1;
    end
    return r;
  endfunction

  task automatic apply_data(input vec_t v);
    DATA0   = v.d0;
    DATA1   = v.d1;
    DATA2   = v.d2;
    DATA3   = v.d3;
    max_idx = v.idx;
  endtask

  task automatic check_accept(input vec_t v);
    cur_j = 0;
    check("accept_busy", 32'(busy), 32'd1);
    check("accept_done", 32'(done), 32'd0);
    check("accept_out", 32'(out), 32'd0);
    check("accept_err", 32'(err), 32'(v.err));
    check("accept_ovr", 32'(ovr), 32'd0);
  endtask

  task automatic run_body(input vec_t v);
    for (int j = 1; j <= v.done_at + 1; j++) begin
      trig = (j == v.ovr_at);
      // Live inputs are scrambled mid-run; only the shadow copies may matter.
      if (j == 2) begin
        DATA0   = 16'($urandom);
        DATA1   = 16'($urandom);
        DATA2   = 16'($urandom);
        DATA3   = 16'($urandom);
        max_idx = 2'($urandom);
      end
      tick();
      cur_j = j;
      check("out", 32'(out), 32'(exp_out(v, j)));
      check("busy", 32'(busy), 32'(j < v.done_at));
      check("done", 32'(done), 32'(j == v.done_at));
      check("ovr", 32'(ovr), 32'(v.ovr_at != 0 && j >= v.ovr_at));
      check("err", 32'(err), 32'(v.err));
    end
    trig = 1'b0;
  endtask

  task automatic run_scenario(input vec_t v);
    apply_data(v);
    trig = 1'b0;
    tick();
    trig = 1'b1;
    tick();
    trig = 1'b0;
    check_accept(v);
    run_body(v);
  endtask

  initial begin
    vec_t v;
    n_checks = 0;
    n_fail   = 0;
    cur_sc   = -1;
    cur_j    = 0;

    vecs[0] = '{16'd10, 16'd20, 16'd30, 16'd40, 2'd3, 11, 21, 31, 41, 49, 1'b0, 5};
    vecs[1] = '{16'd0, 16'd0, 16'd5, 16'd5, 2'd2, 1, 1, 6, 6, 14, 1'b0, 0};
    vecs[2] = '{16'd50, 16'd10, 16'd10, 16'd10, 2'd1, -1, 11, 11, 11, 19, 1'b1, 0};
    vecs[3] = '{16'd7, 16'd3, 16'd7, 16'd1, 2'd0, 8, 4, 8, 2, 16, 1'b0, 16};
    vecs[4] = '{16'd0, 16'd100, 16'hFFFE, 16'hFFFF, 2'd3, 1, 101, 65535, 65536, 65544, 1'b0, 0};

    reset = 1'b1;
    trig  = 1'b0;
    DATA0 = '0;
    DATA1 = '0;
    DATA2 = '0;
    DATA3 = '0;
    max_idx = '0;
    #2 reset = 1'b0;
    #2;
    check("rst_out", 32'(out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ovr", 32'(ovr), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    tick();
    tick();
    #2 reset = 1'b1;
    tick();
    check("idle_busy", 32'(busy), 32'd0);

    for (int s = 0; s < 5; s++) begin
      cur_sc = s;
      run_scenario(vecs[s]);
    end

    // Reset mid-run with outputs, ovr and err all set, then trig held high through release.
    cur_sc = 5;
    v = vecs[2];
    apply_data(v);
    trig = 1'b0;
    tick();
    trig = 1'b1;
    tick();
    trig = 1'b0;
    for (int j = 1; j <= 15; j++) begin
      trig = (j == 5);
      tick();
    end
    trig  = 1'b0;
    cur_j = 15;
    check("pre_rst_out", 32'(out), 32'h0000000e);
    check("pre_rst_ovr", 32'(ovr), 32'd1);
    check("pre_rst_err", 32'(err), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("async_out", 32'(out), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_done", 32'(done), 32'd0);
    check("async_ovr", 32'(ovr), 32'd0);
    check("async_err", 32'(err), 32'd0);
    v = vecs[0];
    v.ovr_at = 0;
    apply_data(v);
    trig = 1'b1;
    #2 reset = 1'b1;
    tick();
    check_accept(v);
    run_body(v);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
